md_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core.
- Executes mult/multu/div/divu and mthi/mtlo. Owns the architectural HI/LO registers.
- Runs alongside the single-cycle ALU and reads the same forwarded operand buses (data1 = rs, data2 = rt).
- Exposes busy so the hazard unit stalls any later HI/LO-touching instruction in ID.

---
 rtl/md_unit.sv | 166 ++++++++++++++++
 tb/tb_md_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers (optional madd/maddu when MD_MADD_EN is defined).
// Latency: mult/multu/madd/maddu busy MULT_CYCLES, div/divu busy DIV_CYCLES; mthi/mtlo write HI/LO one edge after start.
// Backpressure: busy tells the hazard unit to stall; a start seen while busy or with a reserved op is dropped.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] hi_n, lo_n;
  logic        wr_pend;

  // Both products are taken as the low 64 bits of a 64x64 multiply; sign
  // extension of the operands makes the signed case exact.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{data1[31]}}, data1} * {{32{data2[31]}}, data2};
  assign prod_u = {32'd0, data1} * {32'd0, data2};

  // One shared unsigned divider. Signed divide runs on magnitudes and fixes
  // signs afterwards, which also gives 0x80000000 / -1 = 0x80000000 without
  // relying on the simulator's overflow behaviour.
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs, dvd, dvs, dvs_safe, q, r, sq, sr;
  assign a_neg    = data1[31];
  assign b_neg    = data2[31];
  assign a_abs    = a_neg ? (32'd0 - data1) : data1;
  assign b_abs    = b_neg ? (32'd0 - data2) : data2;
  assign dvd      = op[0] ? data1 : a_abs;
  assign dvs      = op[0] ? data2 : b_abs;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q        = dvd / dvs_safe;
  assign r        = dvd % dvs_safe;
  assign sq       = (a_neg ^ b_neg) ? (32'd0 - q) : q;
  assign sr       = a_neg ? (32'd0 - r) : r;

  logic        launch, mt_hi, mt_lo, res_wr;
  logic [31:0] res_hi, res_lo;
  logic [3:0]  res_cnt;

  // Decode the op and form the pending result and busy length.
  always_comb begin
    launch  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    res_wr  = 1'b1;
    res_hi  = hi;
    res_lo  = lo;
    res_cnt = 4'(MULT_CYCLES);
    case (op)
      OP_MULT: begin
        launch = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        launch = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        launch  = 1'b1;
        res_cnt = 4'(DIV_CYCLES);
        res_wr  = (data2 != 32'd0);
        res_hi  = sr;
        res_lo  = sq;
      end
      OP_DIVU: begin
        launch  = 1'b1;
        res_cnt = 4'(DIV_CYCLES);
        res_wr  = (data2 != 32'd0);
        res_hi  = r;
        res_lo  = q;
      end
      OP_MTHI: mt_hi = 1'b1;
      OP_MTLO: mt_lo = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD: begin
        launch = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
      OP_MADDU: begin
        launch = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_u;
      end
`endif
      default: ;
    endcase
  end

  logic accept, done;
  assign accept = start && (state == IDLE);
  assign done   = (state == RUN) && (cnt == 4'd1);
  assign busy   = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: IDLE -> RUN on an accepted launch, RUN -> IDLE on the last count.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && launch) state_nx = RUN;
      RUN:  if (cnt == 4'd1)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch the pending result at launch, count down, commit at the end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_n    <= 32'd0;
      lo_n    <= 32'd0;
      wr_pend <= 1'b0;
    end else begin
      if (accept && mt_hi) hi <= data1;
      if (accept && mt_lo) lo <= data1;
      if (accept && launch) begin
        hi_n    <= res_hi;
        lo_n    <= res_lo;
        wr_pend <= res_wr;
        cnt     <= res_cnt;
      end
      if (state == RUN) begin
        if (done) begin
          cnt     <= 4'd0;
          wr_pend <= 1'b0;
          if (wr_pend) begin
            hi <= hi_n;
            lo <= lo_n;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus for md_unit with a scoreboard queue drained by a completion monitor.
// Latency: expectations are checked when busy falls (launch ops) or one edge after start (mthi/mtlo).
// Backpressure: the driver waits on busy with a bounded cycle budget before issuing the next op.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] data1 = 32'd0;
  logic [31:0] data2 = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .data1(data1), .data2(data2), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start pulse; caller is at a negedge, returns at the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    data1 = a;
    data2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [31:0] eh, input logic [31:0] el, input int len);
    exp_t e;
    e.name = name;
    e.hi   = eh;
    e.lo   = el;
    e.len  = len;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      vectors++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
    @(negedge clk);
  endtask

  // Monitor: hi/lo must hold during busy; when busy falls, pop and compare.
  initial begin
    int run_len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0;
        continue;
      end
      if (busy) begin
        run_len++;
        chk("hold_hi", hi, model_hi);
        chk("hold_lo", lo, model_lo);
      end else if (run_len > 0) begin
        if (sbq.size() == 0) begin
          errors++;
          vectors++;
          $display("FAIL unexpected_completion: busy ran %0d cycles, required no operation", run_len);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_len"}, 32'(run_len), 32'(e.len));
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          model_hi = e.hi;
          model_lo = e.lo;
        end
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    expect_op("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult_neg");

    expect_op("multu_max", 32'hFFFFFFFE, 32'h00000001, 5);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu_max");

    expect_op("mult_pos", 32'h3FFFFFFF, 32'h00000001, 5);
    issue(3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_idle("mult_pos");

    expect_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg");

    expect_op("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'b011, 32'd7, 32'd0);
    wait_idle("divu_zero");

    expect_op("div_ovf", 32'h00000000, 32'h80000000, 10);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    // A mult pulse mid-divide must neither replace the result nor reload the count.
    expect_op("divu_busy_start", 32'd2, 32'd14, 10);
    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4);
    wait_idle("divu_busy_start");

    issue(3'b100, 32'h12345678, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    model_hi = 32'h12345678;
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    model_lo = 32'h9ABCDEF0;

`ifndef MD_MADD_EN
    issue(3'b110, 32'd5, 32'd5);
    @(negedge clk);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h12345678);
    chk("rsvd_lo", lo, 32'h9ABCDEF0);
`endif

    // Reset in the middle of a divide: result dropped, registers cleared at once.
    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4);
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    expect_op("mult_after_rst", 32'd0, 32'd12, 5);
    issue(3'b000, 32'd3, 32'd4);
    wait_idle("mult_after_rst");

`ifdef MD_MADD_EN
    issue(3'b100, 32'd0, 32'd0);
    model_hi = 32'd0;
    issue(3'b101, 32'hFFFFFFFF, 32'd0);
    model_lo = 32'hFFFFFFFF;
    expect_op("madd_carry", 32'd1, 32'd0, 5);
    issue(3'b110, 32'd1, 32'd1);
    wait_idle("madd_carry");
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
